// File: rtl/hog_pkg.sv
// hog_pkg: default widths, FSM state encoding and clog2 helper shared by the HOG block normaliser.
package hog_pkg;
  function automatic int clog2(input int v);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  localparam int BIN_W = 20;
  localparam int FEA_W = 12;
  localparam int QUO_W = 16;
  localparam int SUM_W = BIN_W + clog2(36);
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SUM, S_DIV, S_SQRT, S_EMIT} state_t;
endpackage

// File: rtl/hog_div_seq.sv
// hog_div_seq: restoring bit-serial divider, q = floor(a*2^Q_W/b) in Q_W cycles; all-ones when a>=b.
module hog_div_seq
  import hog_pkg::*;
#(
  parameter int A_W = 20,
  parameter int B_W = 26,
  parameter int Q_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [Q_W-1:0] q
);
  localparam int CW = clog2(Q_W + 1);
  logic [B_W-1:0] rem_q, rem_d, rem_in;
  logic [Q_W-1:0] quo_q, quo_d;
  logic [CW-1:0]  cnt_q, cnt_d, left;
  logic           busy_q, busy_d, sat_q, sat_d, act, ge;
  logic [B_W:0]   sh;
  always_comb begin
    act    = start || busy_q;
    rem_in = start ? B_W'(a) : rem_q;
    left   = start ? CW'(Q_W) : cnt_q;
    sh     = {rem_in, 1'b0};
    ge     = sh >= {1'b0, b};
    rem_d  = act ? (ge ? B_W'(sh - {1'b0, b}) : sh[B_W-1:0]) : rem_q;
    quo_d  = act ? {(start ? {(Q_W-1){1'b0}} : quo_q[Q_W-2:0]), ge} : quo_q;
    cnt_d  = act ? left - CW'(1) : cnt_q;
    busy_d = act && left != CW'(1);
    sat_d  = start ? (B_W'(a) >= b) : sat_q;
    done   = act && left == CW'(1);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      sat_q  <= sat_d;
    end
  assign busy = busy_q;
  assign q    = sat_q ? '1 : quo_q;
endmodule

// File: rtl/hog_block_norm.sv
// hog_block_norm: 2x2-block L1-sqrt HOG normaliser with valid/ready and block/frame tags.
// Define HOG_NORM_CLIP_EN to saturate every root at CLIP.
module hog_block_norm
  import hog_pkg::*;
#(
  parameter int NBIN    = 9,
  parameter int BIN_I   = 16,
  parameter int BIN_F   = 4,
  parameter int FEA_I   = 4,
  parameter int FEA_F   = 8,
  parameter int CELLS_X = 40,
  parameter int CELLS_Y = 30,
  parameter int EPS     = 1,
  parameter int CLIP    = 8'h80
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NBIN*(BIN_I+BIN_F)-1:0]   i_bin,
  input  logic                            i_valid,
  output logic                            i_ready,
  output logic [FEA_I+FEA_F-1:0]          o_fea,
  output logic                            o_valid,
  input  logic                            o_ready,
  output logic                            o_blk_last,
  output logic                            o_frm_last
);
  localparam int BW = BIN_I + BIN_F;
  localparam int QW = 2 * FEA_F;
  localparam int SW = BW + clog2(4 * NBIN);
  localparam int N  = CELLS_X + 1;
  localparam int PW = clog2(N);
  localparam int XW = clog2(CELLS_X + 1);
  localparam int YW = clog2(CELLS_Y + 1);
  localparam int KW = clog2(NBIN + 1);
  localparam int RW = clog2(FEA_F + 1);
`ifdef HOG_NORM_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif
  typedef logic [NBIN*BW-1:0] cell_t;

  state_t                 state_q, state_d;
  cell_t                  mem_q [N];
  cell_t                  tl_q, tl_d, cur;
  logic [XW-1:0]          col_q, col_d;
  logic [YW-1:0]          row_q, row_d;
  logic [PW-1:0]          wp_q, wp_d, br_q, br_d, tr_ix, bl_ix;
  logic [1:0]             cel_q, cel_d;
  logic [KW-1:0]          bin_q, bin_d;
  logic [SW-1:0]          sum_q, sum_d, cell_sum;
  logic [FEA_F-1:0]       root_q, root_d, trial, root_n, root_c;
  logic [RW-1:0]          sb_q, sb_d;
  logic [FEA_I+FEA_F-1:0] fea_q, fea_d;
  logic [QW-1:0]          quo, sq;
  logic                   blk_q, blk_d, flast_q, flast_d, rdy_q;
  logic                   acc, last_f, div_start, div_busy, div_done;

  assign i_ready    = state_q == S_IDLE && rdy_q;
  assign acc        = i_valid && i_ready;
  assign last_f     = cel_q == 2'd3 && bin_q == KW'(NBIN - 1);
  assign o_valid    = state_q == S_EMIT;
  assign o_fea      = fea_q;
  assign o_blk_last = o_valid && last_f;
  assign o_frm_last = o_blk_last && flast_q;
  assign div_start  = state_q == S_DIV && !div_busy;
  // TL shares its slot with the incoming BR cell, so it is latched at accept time
  assign tr_ix      = br_q == PW'(N - 1) ? '0 : br_q + PW'(1);
  assign bl_ix      = br_q == '0 ? PW'(N - 1) : br_q - PW'(1);
  assign trial      = root_q | (FEA_F'(1) << sb_q);
  assign sq         = QW'(trial) * QW'(trial);
  assign root_n     = sq <= quo ? trial : root_q;
  assign root_c     = CLIP_EN && root_n > FEA_F'(CLIP) ? FEA_F'(CLIP) : root_n;

  always_comb begin
    cur = cel_q == 2'd0 ? tl_q : cel_q == 2'd1 ? mem_q[tr_ix] : cel_q == 2'd2 ? mem_q[bl_ix] : mem_q[br_q];
    cell_sum = '0;
    for (int i = 0; i < NBIN; i++) cell_sum = cell_sum + SW'(cur[i*BW +: BW]);
  end

  hog_div_seq #(.A_W(BW), .B_W(SW), .Q_W(QW)) u_div (
    .clk  (clk),
    .rst  (rst),
    .start(div_start),
    .a    (cur[bin_q*BW +: BW]),
    .b    (sum_q),
    .busy (div_busy),
    .done (div_done),
    .q    (quo)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    wp_d    = wp_q;
    br_d    = br_q;
    tl_d    = tl_q;
    blk_d   = blk_q;
    flast_d = flast_q;
    cel_d   = cel_q;
    bin_d   = bin_q;
    sum_d   = sum_q;
    root_d  = root_q;
    sb_d    = sb_q;
    fea_d   = fea_q;
    case (state_q)
      S_IDLE: if (acc) begin
        state_d = S_CHECK;
        tl_d    = mem_q[wp_q];
        br_d    = wp_q;
        wp_d    = wp_q == PW'(N - 1) ? '0 : wp_q + PW'(1);
        blk_d   = row_q != '0 && col_q != '0;
        flast_d = row_q == YW'(CELLS_Y - 1) && col_q == XW'(CELLS_X - 1);
        col_d   = col_q == XW'(CELLS_X - 1) ? '0 : col_q + XW'(1);
        row_d   = col_q != XW'(CELLS_X - 1) ? row_q : row_q == YW'(CELLS_Y - 1) ? '0 : row_q + YW'(1);
      end
      S_CHECK: begin
        state_d = blk_q ? S_SUM : S_IDLE;
        cel_d   = '0;
        sum_d   = '0;
      end
      S_SUM: begin
        sum_d   = sum_q + cell_sum + (cel_q == 2'd3 ? SW'(EPS) : '0);
        cel_d   = cel_q + 2'd1;
        bin_d   = '0;
        state_d = cel_q == 2'd3 ? S_DIV : S_SUM;
      end
      S_DIV: if (div_done) begin
        state_d = S_SQRT;
        root_d  = '0;
        sb_d    = RW'(FEA_F - 1);
      end
      S_SQRT: begin
        root_d  = root_n;
        sb_d    = sb_q - RW'(1);
        state_d = sb_q == '0 ? S_EMIT : S_SQRT;
        fea_d   = sb_q == '0 ? {{FEA_I{1'b0}}, root_c} : fea_q;
      end
      S_EMIT: if (o_ready) begin
        state_d = last_f ? S_IDLE : S_DIV;
        bin_d   = bin_q == KW'(NBIN - 1) ? '0 : bin_q + KW'(1);
        cel_d   = bin_q == KW'(NBIN - 1) ? cel_q + 2'd1 : cel_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) if (acc) mem_q[wp_q] <= i_bin;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      wp_q    <= '0;
      br_q    <= '0;
      tl_q    <= '0;
      blk_q   <= 1'b0;
      flast_q <= 1'b0;
      cel_q   <= '0;
      bin_q   <= '0;
      sum_q   <= '0;
      root_q  <= '0;
      sb_q    <= '0;
      fea_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      wp_q    <= wp_d;
      br_q    <= br_d;
      tl_q    <= tl_d;
      blk_q   <= blk_d;
      flast_q <= flast_d;
      cel_q   <= cel_d;
      bin_q   <= bin_d;
      sum_q   <= sum_d;
      root_q  <= root_d;
      sb_q    <= sb_d;
      fea_q   <= fea_d;
      rdy_q   <= 1'b1;
    end
endmodule
